// File: rtl/yrv_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : yrv_multi_timer
// Purpose  : N-channel periodic/one-shot tick generator with sticky pendings,
//            masked interrupt request and a free-running channel-0 tick count.
// Revision : 1.0  initial release
// ============================================================================
module yrv_multi_timer #(
   parameter int         N_CH      = 4,
   parameter int         CNT_W     = 16,
   parameter int         FREE_W    = 16,
   parameter int         CH0_LIMIT = 6249,
   parameter logic [1:0] CH0_MODE  = 2'b01
) (
   input  logic                                      clk,
   input  logic                                      resetb,
   input  logic                                      cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                          cfg_limit,
   input  logic [1:0]                                cfg_mode,
   input  logic [N_CH-1:0]                           int_ack,
   input  logic [N_CH-1:0]                           int_mask,
   output logic [N_CH-1:0]                           tick,
   output logic [N_CH-1:0]                           pending,
   output logic                                      ei_req,
   output logic [FREE_W-1:0]                         free_cnt
);

   localparam int         CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [1:0] MODE_OFF      = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;

   logic [N_CH-1:0]   term;
   logic [FREE_W-1:0] free_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] RST_LIMIT = (i == 0) ? CNT_W'(CH0_LIMIT) : '0;
      localparam logic [1:0]       RST_MODE  = (i == 0) ? CH0_MODE : MODE_OFF;

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] limit_q, limit_d;
      logic [1:0]       mode_q, mode_d;
      logic             tick_q;
      logic             pend_q, pend_d;
      logic             wr, active, hit;

      // Addresses beyond the last channel never match, so such writes vanish.
      assign wr     = cfg_we && (cfg_ch == CH_W'(i));
      assign active = (mode_q == MODE_PERIODIC) || (mode_q == MODE_ONESHOT);
      assign hit    = active && (cnt_q == limit_q);
      assign term[i] = hit && !wr;
      assign pend_d  = ~int_ack[i] & (term[i] | pend_q);

      always_comb begin
         cnt_d   = cnt_q;
         limit_d = limit_q;
         mode_d  = mode_q;
         if (wr) begin
            cnt_d   = '0;
            limit_d = cfg_limit;
            mode_d  = cfg_mode;
         end else if (!active || hit) begin
            cnt_d = '0;
            if (hit && (mode_q == MODE_ONESHOT)) begin
               mode_d = MODE_OFF;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            cnt_q   <= '0;
            limit_q <= RST_LIMIT;
            mode_q  <= RST_MODE;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tick_q  <= term[i];
            pend_q  <= pend_d;
         end
      end

      assign tick[i]    = tick_q;
      assign pending[i] = pend_q;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         free_q <= '0;
      end else if (term[0]) begin
         free_q <= free_q + 1'b1;
      end
   end

   assign free_cnt = free_q;
   assign ei_req   = |(pending & ~int_mask);

endmodule
`default_nettype wire

// File: tb/tb_yrv_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_yrv_multi_timer
// Purpose  : Directed self-checking bench for yrv_multi_timer (two instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_yrv_multi_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance A: default parameters
   logic        rstn_a = 1'b1;
   logic        we_a   = 1'b0;
   logic [1:0]  ch_a   = '0;
   logic [15:0] lim_a  = '0;
   logic [1:0]  mode_a = '0;
   logic [3:0]  ack_a  = '0;
   logic [3:0]  mask_a = '0;
   logic [3:0]  tick_a, pend_a;
   logic        ei_a;
   logic [15:0] free_a;

   // Instance B: 3 channels, short channel 0, narrow free counter
   logic        rstn_b = 1'b1;
   logic        we_b   = 1'b0;
   logic [1:0]  ch_b   = '0;
   logic [7:0]  lim_b  = '0;
   logic [1:0]  mode_b = '0;
   logic [2:0]  ack_b  = '0;
   logic [2:0]  mask_b = '0;
   logic [2:0]  tick_b, pend_b;
   logic        ei_b;
   logic [3:0]  free_b;

   yrv_multi_timer dut_a (
      .clk       (clk),
      .resetb    (rstn_a),
      .cfg_we    (we_a),
      .cfg_ch    (ch_a),
      .cfg_limit (lim_a),
      .cfg_mode  (mode_a),
      .int_ack   (ack_a),
      .int_mask  (mask_a),
      .tick      (tick_a),
      .pending   (pend_a),
      .ei_req    (ei_a),
      .free_cnt  (free_a)
   );

   yrv_multi_timer #(
      .N_CH      (3),
      .CNT_W     (8),
      .FREE_W    (4),
      .CH0_LIMIT (1),
      .CH0_MODE  (2'b01)
   ) dut_b (
      .clk       (clk),
      .resetb    (rstn_b),
      .cfg_we    (we_b),
      .cfg_ch    (ch_b),
      .cfg_limit (lim_b),
      .cfg_mode  (mode_b),
      .int_ack   (ack_b),
      .int_mask  (mask_b),
      .tick      (tick_b),
      .pending   (pend_b),
      .ei_req    (ei_b),
      .free_cnt  (free_b)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Caller sits on a negedge; returns on the negedge after the write edge.
   task automatic write_a(input logic [1:0] ch, input logic [15:0] lim, input logic [1:0] mode);
      we_a = 1'b1; ch_a = ch; lim_a = lim; mode_a = mode;
      @(negedge clk);
      we_a = 1'b0;
   endtask

   task automatic test_reset();
      #1 rstn_a = 1'b0; rstn_b = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tick_a !== 4'h0) begin errors++; $display("FAIL reset_tick: got %h expected 0", tick_a); end
      checks++; if (pend_a !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pend_a); end
      checks++; if (ei_a !== 1'b0) begin errors++; $display("FAIL reset_ei: got %b expected 0", ei_a); end
      checks++; if (free_a !== 16'h0) begin errors++; $display("FAIL reset_free: got %h expected 0", free_a); end
      rstn_a = 1'b1; rstn_b = 1'b1;
   endtask

   task automatic test_ch0_default();
      int seen = 0;
      for (int k = 1; k <= 6249; k++) begin
         @(negedge clk);
         if (tick_a[0]) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL ch0_early_ticks: got %0d expected 0", seen); end
      @(negedge clk);
      checks++; if (tick_a[0] !== 1'b1) begin errors++; $display("FAIL ch0_first_tick: got %b expected 1", tick_a[0]); end
      checks++; if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL ch0_first_pending: got %b expected 1", pend_a[0]); end
      checks++; if (ei_a !== 1'b1) begin errors++; $display("FAIL ch0_first_ei: got %b expected 1", ei_a); end
      checks++; if (free_a !== 16'd1) begin errors++; $display("FAIL ch0_free1: got %0d expected 1", free_a); end
      seen = 0;
      for (int k = 6251; k <= 12499; k++) begin
         @(negedge clk);
         if (tick_a[0]) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL ch0_mid_ticks: got %0d expected 0", seen); end
      @(negedge clk);
      checks++; if (tick_a[0] !== 1'b1) begin errors++; $display("FAIL ch0_second_tick: got %b expected 1", tick_a[0]); end
      checks++; if (free_a !== 16'd2) begin errors++; $display("FAIL ch0_free2: got %0d expected 2", free_a); end
   endtask

   task automatic test_ack();
      ack_a[0] = 1'b1;
      @(negedge clk);
      checks++; if (pend_a[0] !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", pend_a[0]); end
      repeat (6249) @(negedge clk);
      checks++; if (tick_a[0] !== 1'b1) begin errors++; $display("FAIL ack_tick: got %b expected 1", tick_a[0]); end
      checks++; if (pend_a[0] !== 1'b0) begin errors++; $display("FAIL ack_wins: got %b expected 0", pend_a[0]); end
      ack_a[0] = 1'b0;
      repeat (6250) @(negedge clk);
      checks++; if (tick_a[0] !== 1'b1) begin errors++; $display("FAIL ack_release_tick: got %b expected 1", tick_a[0]); end
      checks++; if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL ack_release_pending: got %b expected 1", pend_a[0]); end
      checks++; if (free_a !== 16'd4) begin errors++; $display("FAIL ack_free4: got %0d expected 4", free_a); end
      mask_a[0] = 1'b1;
      #1;
      checks++; if (ei_a !== 1'b0) begin errors++; $display("FAIL mask0_ei: got %b expected 0", ei_a); end
      checks++; if (pend_a[0] !== 1'b1) begin errors++; $display("FAIL mask0_keeps_pending: got %b expected 1", pend_a[0]); end
      @(negedge clk);
   endtask

   task automatic test_periodic_oneshot();
      logic [14:0] obs;
      obs = '0;
      write_a(2'd1, 16'd3, 2'b01);
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         obs[j] = tick_a[1];
      end
      checks++; if (obs !== 15'h0888) begin errors++; $display("FAIL periodic_pattern: got %h expected 0888", obs); end
      checks++; if (ei_a !== 1'b1) begin errors++; $display("FAIL periodic_ei: got %b expected 1", ei_a); end
      // Channel 1 is on its terminal cycle here; the write must suppress the tick.
      write_a(2'd1, 16'd3, 2'b10);
      checks++; if (tick_a[1] !== 1'b0) begin errors++; $display("FAIL write_wins_ch1: got %b expected 0", tick_a[1]); end
      obs = '0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         obs[j] = tick_a[1];
      end
      checks++; if (obs !== 15'h0008) begin errors++; $display("FAIL oneshot_pattern: got %h expected 0008", obs); end
      ack_a[1] = 1'b1;
      @(negedge clk);
      ack_a[1] = 1'b0;
      checks++; if (pend_a[1] !== 1'b0) begin errors++; $display("FAIL ack_ch1: got %b expected 0", pend_a[1]); end
   endtask

   task automatic test_mask();
      logic [4:0] obs;
      obs = '0;
      mask_a[2] = 1'b1;
      write_a(2'd2, 16'd0, 2'b01);
      checks++; if (tick_a[2] !== 1'b0) begin errors++; $display("FAIL ch2_write_edge: got %b expected 0", tick_a[2]); end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         obs[j] = tick_a[2];
      end
      checks++; if (obs !== 5'h1f) begin errors++; $display("FAIL ch2_every_cycle: got %h expected 1f", obs); end
      checks++; if (pend_a[2] !== 1'b1) begin errors++; $display("FAIL ch2_pending: got %b expected 1", pend_a[2]); end
      checks++; if (ei_a !== 1'b0) begin errors++; $display("FAIL ch2_masked_ei: got %b expected 0", ei_a); end
      mask_a[2] = 1'b0;
      #1;
      checks++; if (ei_a !== 1'b1) begin errors++; $display("FAIL ch2_unmask_ei: got %b expected 1", ei_a); end
      @(negedge clk);
      write_a(2'd2, 16'd0, 2'b00);
      checks++; if (tick_a[2] !== 1'b0) begin errors++; $display("FAIL ch2_off_tick: got %b expected 0", tick_a[2]); end
      ack_a[2] = 1'b1;
      @(negedge clk);
      ack_a[2] = 1'b0;
      checks++; if (pend_a[2] !== 1'b0) begin errors++; $display("FAIL ch2_ack: got %b expected 0", pend_a[2]); end
      checks++; if (ei_a !== 1'b0) begin errors++; $display("FAIL ch2_final_ei: got %b expected 0", ei_a); end
   endtask

   task automatic test_write_on_terminal();
      logic [2:0] obs;
      obs = '0;
      write_a(2'd0, 16'd4, 2'b01);
      repeat (4) @(negedge clk);
      write_a(2'd0, 16'd2, 2'b01);
      checks++; if (tick_a[0] !== 1'b0) begin errors++; $display("FAIL write_wins_ch0: got %b expected 0", tick_a[0]); end
      checks++; if (free_a !== 16'd4) begin errors++; $display("FAIL write_wins_free: got %0d expected 4", free_a); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         obs[j] = tick_a[0];
      end
      checks++; if (obs !== 3'b100) begin errors++; $display("FAIL new_period: got %b expected 100", obs); end
      checks++; if (free_a !== 16'd5) begin errors++; $display("FAIL new_period_free: got %0d expected 5", free_a); end
   endtask

   task automatic test_async_reset_wrap();
      logic [31:0] obs;
      logic [3:0]  f30;
      obs = '0;
      f30 = '0;
      @(posedge clk);
      #2 rstn_b = 1'b0;
      #1;
      checks++; if (tick_b !== 3'h0) begin errors++; $display("FAIL b_async_tick: got %h expected 0", tick_b); end
      checks++; if (pend_b !== 3'h0) begin errors++; $display("FAIL b_async_pending: got %h expected 0", pend_b); end
      checks++; if (ei_b !== 1'b0) begin errors++; $display("FAIL b_async_ei: got %b expected 0", ei_b); end
      checks++; if (free_b !== 4'h0) begin errors++; $display("FAIL b_async_free: got %h expected 0", free_b); end
      @(negedge clk);
      rstn_b = 1'b1;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         obs[j] = tick_b[0];
         if (j == 29) f30 = free_b;
      end
      checks++; if (obs !== 32'hAAAA_AAAA) begin errors++; $display("FAIL b_tick_pattern: got %h expected aaaaaaaa", obs); end
      checks++; if (f30 !== 4'd15) begin errors++; $display("FAIL b_free_15: got %0d expected 15", f30); end
      checks++; if (free_b !== 4'd0) begin errors++; $display("FAIL b_free_wrap: got %0d expected 0", free_b); end
   endtask

   task automatic test_out_of_range();
      logic [7:0] obs;
      logic [1:0] others;
      obs = '0;
      others = '0;
      we_b = 1'b1; ch_b = 2'd3; lim_b = 8'd0; mode_b = 2'b01;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (j == 0) we_b = 1'b0;
         obs[j] = tick_b[0];
         others = others | tick_b[2:1];
      end
      checks++; if (obs !== 8'hAA) begin errors++; $display("FAIL oor_ch0: got %h expected aa", obs); end
      checks++; if (others !== 2'b00) begin errors++; $display("FAIL oor_other_channels: got %b expected 00", others); end
   endtask

   initial begin
      test_reset();
      test_ch0_default();
      test_ack();
      test_periodic_oneshot();
      test_mask();
      test_write_on_terminal();
      test_async_reset_wrap();
      test_out_of_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
